iob_eth_csr_read_buf: RTL

Parametrised read-path adapter between the Ethernet core's CSR bus and the internal register/buffer read ports of registers without automatic read logic. It supports up to DEPTH outstanding CSR reads instead of a single transaction, buffers internal responses in an in-order FIFO so the CSR master can apply `rready_i` backpressure, and passes a response straight through when the FIFO is empty. Stray internal responses are detected and flagged.

---
 rtl/iob_eth_csr_read_buf.sv | 104 ++++++++++
 1 files changed

// File: rtl/iob_eth_csr_read_buf.sv
// CSR read-path adapter: up to DEPTH outstanding reads, in-order response FIFO
// with same-cycle bypass when empty, and a sticky flag for stray responses.
module iob_eth_csr_read_buf #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                       clk_i,
  input  logic                       cke_i,
  input  logic                       arst_i,
  input  logic                       valid_i,
  output logic                       ready_o,
  output logic [DATA_W-1:0]          rdata_o,
  output logic                       rvalid_o,
  input  logic                       rready_i,
  output logic                       int_ren_o,
  input  logic                       int_ready_i,
  input  logic [DATA_W-1:0]          int_rdata_i,
  input  logic                       int_rvalid_i,
  output logic [$clog2(DEPTH):0]     pending_o,
  output logic                       err_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [CW-1:0]     cnt;
  logic [CW-1:0]     occ;
  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rptr;
  logic              err;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              space;
  logic              accept;
  logic [CW-1:0]     in_flight;
  logic              legal;
  logic              stray;
  logic              occ_nz;
  logic              pop;
  logic              push;
  logic              head_pop;

  assign space     = (cnt < CW'(DEPTH));
  assign int_ren_o = valid_i & space;
  assign ready_o   = int_ready_i & space;
  assign accept    = valid_i & ready_o;

  // The read accepted this very cycle is already in flight, so a zero-latency
  // internal response is legal and can be bypassed straight to the master.
  assign in_flight = cnt - occ + CW'(accept);
  assign legal     = int_rvalid_i & (in_flight != '0);
  assign stray     = int_rvalid_i & (in_flight == '0);
  assign occ_nz    = (occ != '0);

  always_comb begin
    rvalid_o = 1'b0;
    rdata_o  = '0;
    if (occ_nz) begin
      rvalid_o = 1'b1;
      rdata_o  = mem[rptr];
    end else if (legal) begin
      rvalid_o = 1'b1;
      rdata_o  = int_rdata_i;
    end
  end

  assign pop      = rvalid_o & rready_i;
  assign head_pop = pop & occ_nz;
  // A legal response is buffered unless a same-cycle bypass pop consumes it.
  assign push     = legal & (occ_nz | ~rready_i);

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      cnt  <= '0;
      occ  <= '0;
      wptr <= '0;
      rptr <= '0;
      err  <= 1'b0;
    end else if (cke_i) begin
      cnt <= cnt + CW'(accept) - CW'(pop);
      occ <= occ + CW'(push) - CW'(head_pop);
      if (push) begin
        wptr <= wptr + AW'(1);
      end
      if (head_pop) begin
        rptr <= rptr + AW'(1);
      end
      if (stray) begin
        err <= 1'b1;
      end
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk_i) begin
    if (cke_i && push) begin
      mem[wptr] <= int_rdata_i;
    end
  end

  assign pending_o = cnt;
  assign err_o     = err;

endmodule
